demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream.sv | 109 ++++++++++
 tb/tb_demux_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: routes one input word stream to CHANNELS one-deep output
// registers. Unicast words go to the channel named by in_sel. Broadcast words
// go to every channel. Out-of-range unicast selects are accepted and dropped.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   in_data     - input word (WIDTH)
//   in_sel      - destination channel index (SEL_W)
//   in_bcast    - 1: send the word to all channels, in_sel ignored
//   in_valid    - input word present
//   in_ready    - combinational: the word can be accepted this cycle
//   out_data    - channel i data at [i*WIDTH +: WIDTH]
//   out_valid   - channel i holds a word
//   out_ready   - consumer i takes the word this cycle
//   err_sel     - sticky: an out-of-range in_sel was accepted
//   xfer_cnt    - wrapping count of accepted input words
module demux_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      err_sel,
    output logic [15:0]               xfer_cnt
);

    localparam int unsigned CNT_W = 16;

    if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
        $error("demux_stream: SEL_W must equal clog2(CHANNELS)");
    end

    logic [CHANNELS-1:0] free_c;
    logic [CHANNELS-1:0] load_c;
    logic                sel_ok_c;
    logic                sel_free_c;
    logic                rdy_c;
    logic                xfer_c;

    // Accept/route decision; depends on select, broadcast and channel state only.
    always_comb begin
        free_c     = ~out_valid | out_ready;
        sel_ok_c   = 32'(in_sel) < CHANNELS;
        sel_free_c = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_free_c = free_c[i];
            end
        end

        // Out-of-range unicast words are always taken so the stream cannot lock up.
        if (in_bcast) begin
            rdy_c = &free_c;
        end else if (sel_ok_c) begin
            rdy_c = sel_free_c;
        end else begin
            rdy_c = 1'b1;
        end

        xfer_c = in_valid & rdy_c;

        load_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_c[i] = xfer_c & (in_bcast | (in_sel == SEL_W'(i)));
        end
    end

    assign in_ready = rdy_c;

    // Per-channel holding registers; a load wins over a drain for a bubble-free stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (load_c[i]) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Transfer counter and sticky bad-select flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            xfer_cnt <= '0;
        end else if (xfer_c) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            if (!in_bcast && !sel_ok_c) begin
                err_sel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_demux_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      in_data;
    logic [1:0]        in_sel;
    logic              in_bcast;
    logic              in_valid;
    logic              in_ready;
    logic [CH*W-1:0]   out_data;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
    logic              err_sel;
    logic [15:0]       xfer_cnt;

    // Three-channel instance for the out-of-range select case.
    logic [W-1:0]      in_data3;
    logic [1:0]        in_sel3;
    logic              in_bcast3;
    logic              in_valid3;
    logic              in_ready3;
    logic [3*W-1:0]    out_data3;
    logic [2:0]        out_valid3;
    logic [2:0]        out_ready3;
    logic              err_sel3;
    logic [15:0]       xfer_cnt3;

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    demux_stream #(.WIDTH(W), .CHANNELS(CH), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_sel(err_sel), .xfer_cnt(xfer_cnt)
    );

    demux_stream #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
        .in_bcast(in_bcast3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .err_sel(err_sel3), .xfer_cnt(xfer_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which words each channel holds, plus counters.
    logic [CH-1:0] mv;
    logic [W-1:0]  md [CH];
    logic          m_err;
    logic [15:0]   m_cnt;

    // A channel can take a word unless it holds one its consumer is not taking.
    function automatic logic model_ready();
        if (in_bcast) begin
            for (int i = 0; i < int'(CH); i++) begin
                if (mv[i] && !out_ready[i]) return 1'b0;
            end
            return 1'b1;
        end
        if (int'(in_sel) >= int'(CH)) return 1'b1;
        return !mv[in_sel] || out_ready[in_sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            mv    = '0;
            m_err = 1'b0;
            m_cnt = 16'd0;
            for (int i = 0; i < int'(CH); i++) md[i] = '0;
        end else begin
            acc = in_valid && model_ready();
            for (int i = 0; i < int'(CH); i++) begin
                if (acc && (in_bcast || int'(in_sel) == i)) begin
                    mv[i] = 1'b1;
                    md[i] = in_data;
                end else if (out_ready[i]) begin
                    mv[i] = 1'b0;
                end
            end
            if (acc) begin
                m_cnt = m_cnt + 16'd1;
                if (!in_bcast && int'(in_sel) >= int'(CH)) m_err = 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && check_en) begin
            check("model_in_ready", 32'(in_ready), 32'(model_ready()));
            check("model_out_valid", 32'(out_valid), 32'(mv));
            check("model_err_sel", 32'(err_sel), 32'(m_err));
            check("model_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            for (int i = 0; i < int'(CH); i++) begin
                if (mv[i]) check("model_out_data", 32'(out_data[i*W +: W]), 32'(md[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic bc, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_bcast = bc;
        in_data  = d;
    endtask

    function automatic logic [W-1:0] ch(input int i);
        return out_data[i*W +: W];
    endfunction

    initial begin
        in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '1;
        in_data3 = '0; in_sel3 = '0; in_bcast3 = 1'b0; in_valid3 = 1'b0; out_ready3 = '1;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_err_sel", 32'(err_sel), 32'h0);
        check("reset_xfer_cnt", 32'(xfer_cnt), 32'h0);
        #20;
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Streaming to channels 0..3, each word lands one edge later.
        send(2'd0, 1'b0, 8'h11); #1; check("s_rdy0", 32'(in_ready), 32'h1);
        tick(); check("s_ch0", 32'(ch(0)), 32'h11); check("s_v0", 32'(out_valid[0]), 32'h1);
        send(2'd1, 1'b0, 8'h22);
        tick(); check("s_ch1", 32'(ch(1)), 32'h22); check("s_v1", 32'(out_valid[1]), 32'h1);
        send(2'd2, 1'b0, 8'h33);
        tick(); check("s_ch2", 32'(ch(2)), 32'h33);
        send(2'd3, 1'b0, 8'h44);
        tick(); check("s_ch3", 32'(ch(3)), 32'h44); check("s_cnt", 32'(xfer_cnt), 32'd4);
        in_valid = 1'b0;
        tick();

        // Channel 2 stalled; channel 0 keeps flowing.
        out_ready = 4'b1011;
        send(2'd2, 1'b0, 8'hA5); #1; check("st_rdy_first", 32'(in_ready), 32'h1);
        tick();
        send(2'd2, 1'b0, 8'h5A); #1; check("st_rdy_blocked", 32'(in_ready), 32'h0);
        tick(); check("st_ch2_hold", 32'(ch(2)), 32'hA5); check("st_v2", 32'(out_valid[2]), 32'h1);
        send(2'd0, 1'b0, 8'h77); #1; check("st_rdy_ch0", 32'(in_ready), 32'h1);
        tick(); check("st_ch0", 32'(ch(0)), 32'h77); check("st_ch2_still", 32'(ch(2)), 32'hA5);

        // Broadcast waits for a stalled channel, then fills all channels.
        out_ready = 4'b1001;
        send(2'd1, 1'b0, 8'h3C);
        tick();
        send(2'd0, 1'b1, 8'hC3); #1; check("bc_blocked", 32'(in_ready), 32'h0);
        tick();
        out_ready = 4'b1111; #1; check("bc_open", 32'(in_ready), 32'h1);
        tick();
        check("bc_valid", 32'(out_valid), 32'hF);
        for (int i = 0; i < int'(CH); i++) check("bc_data", 32'(ch(i)), 32'hC3);
        in_valid = 1'b0; in_bcast = 1'b0;
        tick();

        // Back-to-back words on channel 3 with no bubble.
        send(2'd3, 1'b0, 8'h01);
        tick(); check("bb_v1", 32'(out_valid[3]), 32'h1); check("bb_d1", 32'(ch(3)), 32'h01);
        send(2'd3, 1'b0, 8'h02);
        tick(); check("bb_v2", 32'(out_valid[3]), 32'h1); check("bb_d2", 32'(ch(3)), 32'h02);
        send(2'd3, 1'b0, 8'h03);
        tick(); check("bb_v3", 32'(out_valid[3]), 32'h1); check("bb_d3", 32'(ch(3)), 32'h03);
        in_valid = 1'b0;
        tick(); check("bb_drain", 32'(out_valid[3]), 32'h0);

        // Out-of-range select on the three-channel instance.
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFF; #1;
        check("oor_rdy", 32'(in_ready3), 32'h1);
        tick();
        in_valid3 = 1'b0;
        check("oor_valid", 32'(out_valid3), 32'h0);
        check("oor_err", 32'(err_sel3), 32'h1);
        check("oor_cnt", 32'(xfer_cnt3), 32'd1);
        tick(); tick();
        check("oor_err_sticky", 32'(err_sel3), 32'h1);

        // Randomized traffic, checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_bcast  = ($urandom_range(0, 7) == 0);
            in_data   = W'($urandom);
            out_ready = CH'($urandom);
            tick();
        end

        // Fill all channels with no consumer, then reset between edges.
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
        tick();
        out_ready = '0;
        for (int i = 0; i < int'(CH); i++) begin
            send(2'(i), 1'b0, 8'(8'h90 + i));
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        check("rst_mid_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_mid_data", out_data, 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_quiet", 32'(out_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
